// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter sizing shared by the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
  function automatic int cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder of single-bit full-adder cells
// ports: a, b (CHUNK) addends; cin carry in; sum (CHUNK) result; cout carry out of MSB
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[CHUNK];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/sub, CHUNK bits per clock LSB first, valid/ready on both sides
// ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, cin, sub accepted in IDLE;
// out_valid/out_ready handshake the result sum, cout (raw carry, 1 = no borrow on sub), ovf (signed overflow)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = cnt_w(NCHUNK);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic             c_q;
  logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
  logic             ch_cout;
  logic             last;
  assign ch_a = a_q[cnt*CHUNK +: CHUNK];
  assign ch_b = b_q[cnt*CHUNK +: CHUNK];
  assign last = cnt == CW'(NCHUNK - 1);
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a   (ch_a),
    .b   (ch_b),
    .cin (c_q),
    .sum (ch_sum),
    .cout(ch_cout)
  );
  // accumulator with the current chunk merged in; the final result is taken from here
  always_comb begin
    acc_nxt = acc;
    acc_nxt[cnt*CHUNK +: CHUNK] = ch_sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            c_q      <= sub ? ~cin : cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          c_q <= ch_cout;
          cnt <= cnt + 1'b1;
          if (last) begin
            sum       <= acc_nxt;
            cout      <= ch_cout;
            ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector self-checking bench for serial_adder (WIDTH=16, CHUNK=4)
module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum, hold_sum;
  logic        hold_cout, hold_ovf;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wait_in_ready", in_ready, 1);
  endtask
  // present one operation, check latency and result, then consume it
  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                    input logic tc, input logic ts, input logic [15:0] es,
                    input logic ec, input logic eo, input logic early);
    wait_ready();
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~ta; b = ta; cin = ~tc; sub = ~ts;
    chk({tag, "_busy_not_ready"}, in_ready, 0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    if (!early) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_consumed"}, out_valid, 0);
    chk({tag, "_ready_again"}, in_ready, 1);
    chk({tag, "_sum_held"}, sum, es);
    out_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", in_ready, 1);
    op("add_basic", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);
    op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op("sub_bin",   16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);
    op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    op("add_cin",   16'h0F0F, 16'h00F0, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    // backpressure: hold the result for three cycles while in_valid pulses are ignored
    wait_ready();
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    chk("bp_sum", sum, 16'h0200);
    hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 16'h1111; b = 16'h2222;
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum_stable", sum, 16'h0200);
      chk("bp_cout_stable", {hold_cout, cout}, 2'b00);
      chk("bp_ovf_stable", {hold_ovf, ovf}, 2'b00);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_consumed", out_valid, 0);
    chk("bp_ready_again", in_ready, 1);
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_no_queued_op", out_valid, 0);
    chk("bp_sum_held_idle", sum, hold_sum);
    // reset in the middle of BUSY discards the operation
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_never_presented", out_valid, 0);
    op("post_rst", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
